// File: rtl/exu_div_ctl.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per ITER cycle, then a sign-fixup cycle, then a one-cycle result pulse.
module exu_div_ctl #(
  parameter bit SPECIAL_EARLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        scan_mode,
  input  logic        freeze,
  input  logic        flush,
  input  logic        dp_valid,
  input  logic        dp_unsign,
  input  logic        dp_rem,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        div_ready,
  output logic        out_valid,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic [31:0] a_q, a_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        rem_sel_q, rem_sel_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [31:0] out_q, out_d;

  logic        in_neg_a, in_neg_b, in_div0, in_ovf;
  logic [31:0] in_a_mag, in_b_mag;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic [31:0] q_fix, r_fix;

  logic unused_ok;
  assign unused_ok = &{1'b0, scan_mode, rem_q[32]};

  // Architectural results for divide-by-zero and signed overflow.
  function automatic logic [31:0] special_result(input logic is_div0, input logic want_rem,
                                                 input logic [31:0] dividend);
    if (is_div0) special_result = want_rem ? dividend : 32'hFFFF_FFFF;
    else         special_result = want_rem ? 32'h0 : 32'h8000_0000;
  endfunction

  always_comb begin
    in_neg_a = ~dp_unsign & a[31];
    in_neg_b = ~dp_unsign & b[31];
    in_a_mag = in_neg_a ? (~a + 32'd1) : a;
    in_b_mag = in_neg_b ? (~b + 32'd1) : b;
    in_div0  = (b == 32'h0);
    in_ovf   = ~dp_unsign & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

    shifted  = {rem_q[31:0], quot_q[31]};
    trial    = {1'b0, shifted} - {2'b00, b_mag_q};

    q_fix    = (neg_a_q ^ neg_b_q) ? (~quot_q + 32'd1) : quot_q;
    r_fix    = neg_a_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    b_mag_d   = b_mag_q;
    a_d       = a_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    rem_sel_d = rem_sel_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    out_d     = out_q;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (dp_valid) begin
            a_d       = a;
            rem_sel_d = dp_rem;
            neg_a_d   = in_neg_a;
            neg_b_d   = in_neg_b;
            b_mag_d   = in_b_mag;
            quot_d    = in_a_mag;
            rem_d     = 33'd0;
            cnt_d     = 5'd0;
            div0_d    = in_div0;
            ovf_d     = in_ovf;
            if (SPECIAL_EARLY && (in_div0 || in_ovf)) begin
              out_d   = special_result(in_div0, dp_rem, a);
              state_d = DONE;
            end else begin
              state_d = ITER;
            end
          end
        end
        ITER: begin
          // A clear borrow bit means the shifted remainder covers the divisor.
          if (!trial[33]) begin
            rem_d  = trial[32:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = shifted;
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIX;
        end
        FIX: begin
          if (div0_q || ovf_q) out_d = special_result(div0_q, rem_sel_q, a_q);
          else                 out_d = rem_sel_q ? r_fix : q_fix;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_q     <= 33'd0;
      quot_q    <= 32'd0;
      b_mag_q   <= 32'd0;
      a_q       <= 32'd0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      b_mag_q   <= b_mag_d;
      a_q       <= a_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      rem_sel_q <= rem_sel_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
    end
  end

  assign div_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE) && !flush;
  assign out       = out_q;

endmodule

// File: tb/tb_exu_div_ctl.sv
// Bench for exu_div_ctl: an early-special instance and a full-latency instance share stimulus;
// a per-instance scoreboard checks every result pulse and the latency from the accept cycle.
module tb_exu_div_ctl;

  logic        clk, rst_l, scan_mode, freeze, flush, dp_valid, dp_unsign, dp_rem;
  logic [31:0] a, b;
  logic        rdy0, vld0, rdy1, vld1;
  logic [31:0] out0, out1;

  exu_div_ctl #(.SPECIAL_EARLY(1'b1)) dut0 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .freeze(freeze), .flush(flush),
    .dp_valid(dp_valid), .dp_unsign(dp_unsign), .dp_rem(dp_rem), .a(a), .b(b),
    .div_ready(rdy0), .out_valid(vld0), .out(out0));

  exu_div_ctl #(.SPECIAL_EARLY(1'b0)) dut1 (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .freeze(freeze), .flush(flush),
    .dp_valid(dp_valid), .dp_unsign(dp_unsign), .dp_rem(dp_rem), .a(a), .b(b),
    .div_ready(rdy1), .out_valid(vld1), .out(out1));

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat0 = -1, lat1 = -1;
  int pulses0 = 0, pulses1 = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_l && vld0) begin
      logic [31:0] e;
      pulses0++;
      checks++;
      if (q0.size() == 0) begin
        $display("FAIL early_unexpected_valid actual out=%08h required no result pulse", out0);
      end else begin
        e = q0.pop_front();
        lat0 = cyc - acc_cyc;
        if (out0 !== e) $display("FAIL early_result actual=%08h required=%08h", out0, e);
        else begin
          passed++;
          $display("early  result %08h latency %0d", out0, lat0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_l && vld1) begin
      logic [31:0] e;
      pulses1++;
      checks++;
      if (q1.size() == 0) begin
        $display("FAIL full_unexpected_valid actual out=%08h required no result pulse", out1);
      end else begin
        e = q1.pop_front();
        lat1 = cyc - acc_cyc;
        if (out1 !== e) $display("FAIL full_result actual=%08h required=%08h", out1, e);
        else begin
          passed++;
          $display("full   result %08h latency %0d", out1, lat1);
        end
      end
    end
  end

  function automatic logic [31:0] ref_div(input bit u, input bit r, input logic [31:0] x,
                                          input logic [31:0] y);
    int sx, sy;
    if (y == 32'h0) return r ? x : 32'hFFFF_FFFF;
    if (u) return r ? (x % y) : (x / y);
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
    sx = x;
    sy = y;
    return r ? (sx % sy) : (sx / sy);
  endfunction

  task automatic start_op(input bit u, input bit r, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
    int t = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    dp_valid = 1'b1; dp_unsign = u; dp_rem = r; a = x; b = y;
    acc_cyc = cyc;
    lat0 = -1;
    lat1 = -1;
    q0.push_back(exp);
    q1.push_back(exp);
    @(posedge clk);
    #1 dp_valid = 1'b0;
  endtask

  task automatic finish_op(input int l0, input int l1, input string name);
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      $display("FAIL %s_timeout actual pending=%0d/%0d required 0/0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end else passed++;
    checks++;
    if (lat0 !== l0) $display("FAIL %s_latency_early actual=%0d required=%0d", name, lat0, l0);
    else passed++;
    checks++;
    if (lat1 !== l1) $display("FAIL %s_latency_full actual=%0d required=%0d", name, lat1, l1);
    else passed++;
  endtask

  task automatic do_op(input bit u, input bit r, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int l0, input int l1, input string name);
    start_op(u, r, x, y, exp);
    finish_op(l0, l1, name);
  endtask

  task automatic test_reset();
    rst_l = 1'b0; scan_mode = 1'b0; freeze = 1'b0; flush = 1'b0;
    dp_valid = 1'b0; dp_unsign = 1'b0; dp_rem = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy0, vld0, out0, rdy1, vld1, out1} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0})
      $display("FAIL reset_state actual rdy=%b%b vld=%b%b out=%08h/%08h required rdy=11 vld=00 out=0",
               rdy0, rdy1, vld0, vld1, out0, out1);
    else passed++;
  endtask

  task automatic test_unsigned();
    do_op(1'b1, 1'b0, 32'd100, 32'd7, 32'h0000_000E, 34, 34, "divu_100_7");
    do_op(1'b1, 1'b1, 32'd100, 32'd7, 32'h0000_0002, 34, 34, "remu_100_7");
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 34, "divu_max_1");
  endtask

  task automatic test_signed();
    do_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34, "div_m7_2");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34, "rem_m7_2");
  endtask

  task automatic test_div_zero();
    do_op(1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 34, "div_by_zero");
    do_op(1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 34, "rem_by_zero");
  endtask

  task automatic test_overflow();
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34, "div_ovf");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 34, "rem_ovf");
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 34, "divu_ovf_ops");
  endtask

  task automatic test_flush();
    int p0, p1;
    // A request presented together with flush must be dropped.
    @(negedge clk);
    dp_valid = 1'b1; flush = 1'b1; dp_unsign = 1'b1; dp_rem = 1'b0; a = 32'd9; b = 32'd3;
    @(negedge clk);
    dp_valid = 1'b0; flush = 1'b0;
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1)
      $display("FAIL flush_drop_request actual rdy=%b%b required 11", rdy0, rdy1);
    else passed++;
    p0 = pulses0;
    p1 = pulses1;
    start_op(1'b1, 1'b0, 32'd100, 32'd7, 32'h0000_000E);
    q0.delete();
    q1.delete();
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1)
      $display("FAIL flush_ready actual rdy=%b%b required 11", rdy0, rdy1);
    else passed++;
    repeat (40) @(negedge clk);
    checks++;
    if (pulses0 !== p0 || pulses1 !== p1)
      $display("FAIL flush_no_valid actual pulses=%0d/%0d required %0d/%0d", pulses0, pulses1, p0, p1);
    else passed++;
    do_op(1'b1, 1'b0, 32'd50, 32'd5, 32'h0000_000A, 34, 34, "divu_50_5");
  endtask

  task automatic test_freeze();
    start_op(1'b1, 1'b0, 32'd100, 32'd7, 32'h0000_000E);
    repeat (10) @(posedge clk);
    #1 freeze = 1'b1;
    repeat (5) @(posedge clk);
    #1 freeze = 1'b0;
    finish_op(39, 39, "freeze5");
  endtask

  task automatic test_async_reset();
    start_op(1'b1, 1'b0, 32'd100, 32'd7, 32'h0000_000E);
    repeat (12) @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if ({vld0, rdy0, out0, vld1, rdy1, out1} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0})
      $display("FAIL async_reset actual vld=%b%b rdy=%b%b out=%08h/%08h required vld=00 rdy=11 out=0",
               vld0, vld1, rdy0, rdy1, out0, out1);
    else passed++;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bit u, r;
      logic [31:0] x, y;
      u = $urandom_range(0, 1);
      r = $urandom_range(0, 1);
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : 32'($urandom);
      if (i == 5) y = 32'h0;
      do_op(u, r, x, y, ref_div(u, r, x, y), (y == 32'h0) ? 1 : 34, 34, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_freeze();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
